// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART Rx sequencer: state encoding, default
// oversampling/frame sizes and the positions of the framing bits.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    DONE
  } rxState_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAME_BITS_DEF = 11;

  // Frame layout: start bit first, then data LSB-first, parity, stop last.
  localparam int START_IDX  = 0;
  localparam int PARITY_IDX = FRAME_BITS_DEF - 2;
  localparam int STOP_IDX   = FRAME_BITS_DEF - 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line plus a falling-edge detector
// on the synchronized value. Everything resets to the idle (high) line level.
module uart_rx_sync (
  input  logic Clk,
  input  logic ResetN,
  input  logic RxIn,
  output logic RxS,
  output logic FallEdge
);

  logic rxMeta;
  logic rxPrev;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rxMeta <= 1'b1;
      RxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= RxIn;
      RxS    <= rxMeta;
      rxPrev <= RxS;
    end
  end

  assign FallEdge = rxPrev & ~RxS;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART Rx sequencer: finds the start bit, times bit cells from Tick16 and strobes
// each mid-bit sample into the frame register. Option: UART_RX_START_VERIFY_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic Tick16,
  input  logic Enable,
  input  logic RxIn,
  output logic ShiftEn,
  output logic ShiftBit,
  output logic FrameDone,
  output logic FramingErr,
  output logic Busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(START_IDX + 1);
  localparam logic [BIT_W-1:0]  BIT_END   = BIT_W'(FRAME_BITS);

  rxState_t          state, stateNext;
  logic [TICK_W-1:0] tickCnt, tickNext;
  logic [BIT_W-1:0]  bitCnt, bitNext, bitInc;
  logic              shiftEnNext, shiftBitNext, frameDoneNext, framingErrNext;
  logic              stopErr, stopErrNext;
  logic              edgePend, edgePendNext;
  logic              rxS, fallEdge, startFalse;

  uart_rx_sync uSync (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .RxIn    (RxIn),
    .RxS     (rxS),
    .FallEdge(fallEdge)
  );

`ifdef UART_RX_START_VERIFY_EN
  assign startFalse = rxS;
`else
  assign startFalse = 1'b0;
`endif

  assign bitInc = bitCnt + 1'b1;
  assign Busy   = (state == START) || (state == SHIFT);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      tickCnt    <= '0;
      bitCnt     <= '0;
      ShiftEn    <= 1'b0;
      ShiftBit   <= 1'b1;
      FrameDone  <= 1'b0;
      FramingErr <= 1'b0;
      stopErr    <= 1'b0;
      edgePend   <= 1'b0;
    end else begin
      state      <= stateNext;
      tickCnt    <= tickNext;
      bitCnt     <= bitNext;
      ShiftEn    <= shiftEnNext;
      ShiftBit   <= shiftBitNext;
      FrameDone  <= frameDoneNext;
      FramingErr <= framingErrNext;
      stopErr    <= stopErrNext;
      edgePend   <= edgePendNext;
    end
  end

  // An edge arriving during the one-cycle DONE state is remembered in edgePend
  // so that back-to-back frames still start in IDLE on the following cycle.
  always_comb begin
    stateNext      = state;
    tickNext       = tickCnt;
    bitNext        = bitCnt;
    shiftEnNext    = 1'b0;
    shiftBitNext   = ShiftBit;
    frameDoneNext  = 1'b0;
    framingErrNext = FramingErr;
    stopErrNext    = stopErr;
    edgePendNext   = 1'b0;

    case (state)
      IDLE: begin
        tickNext = '0;
        bitNext  = '0;
        if (Enable && (fallEdge || edgePend)) begin
          stateNext = START;
        end
      end

      START: begin
        if (!Enable) begin
          stateNext = IDLE;
          tickNext  = '0;
          bitNext   = '0;
        end else if (Tick16) begin
          if (tickCnt == TICK_MID) begin
            tickNext = '0;
            if (startFalse) begin
              stateNext = IDLE;
              bitNext   = '0;
            end else begin
              shiftEnNext  = 1'b1;
              shiftBitNext = rxS;
              bitNext      = BIT_FIRST;
              stateNext    = SHIFT;
            end
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
      end

      SHIFT: begin
        if (!Enable) begin
          stateNext = IDLE;
          tickNext  = '0;
          bitNext   = '0;
        end else if (Tick16) begin
          if (tickCnt == TICK_LAST) begin
            tickNext     = '0;
            shiftEnNext  = 1'b1;
            shiftBitNext = rxS;
            bitNext      = bitInc;
            if (bitInc == BIT_END) begin
              stopErrNext = ~rxS;
              stateNext   = DONE;
            end
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
      end

      DONE: begin
        frameDoneNext  = 1'b1;
        framingErrNext = stopErr;
        edgePendNext   = fallEdge;
        tickNext       = '0;
        bitNext        = '0;
        stateNext      = IDLE;
      end

      default: begin
        stateNext = IDLE;
        tickNext  = '0;
        bitNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: serial frames driven bit by bit,
// strobes logged by a monitor, expectations hand-computed per frame.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int CLK_PER_TICK = 4;
  localparam int BIT_CLKS     = OVERSAMPLE_DEF * CLK_PER_TICK;

  logic Clk, ResetN, Tick16, Enable, RxIn;
  logic ShiftEn, ShiftBit, FrameDone, FramingErr, Busy;

  int   checks     = 0;
  int   errors     = 0;
  int   strobeCnt  = 0;
  int   doneCnt    = 0;
  int   overlapCnt = 0;
  int   cycCnt     = 0;
  logic errAtDone  = 1'b0;
  logic bitLog    [0:511];
  int   strobeCyc [0:511];

  uart_rx_ctrl dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .Tick16    (Tick16),
    .Enable    (Enable),
    .RxIn      (RxIn),
    .ShiftEn   (ShiftEn),
    .ShiftBit  (ShiftBit),
    .FrameDone (FrameDone),
    .FramingErr(FramingErr),
    .Busy      (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    Tick16 = 1'b0;
    forever begin
      repeat (CLK_PER_TICK - 1) @(negedge Clk);
      Tick16 = 1'b1;
      @(negedge Clk);
      Tick16 = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor samples 1ns after each rising edge and logs every strobe with its cycle.
  always @(posedge Clk) begin
    #1;
    cycCnt++;
    if (ShiftEn) begin
      if (strobeCnt < 512) begin
        bitLog[strobeCnt]    = ShiftBit;
        strobeCyc[strobeCnt] = cycCnt;
      end
      strobeCnt++;
    end
    if (FrameDone) begin
      doneCnt++;
      errAtDone = FramingErr;
    end
    if (ShiftEn && FrameDone) overlapCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopVal);
    logic [10:0] frame;
    frame             = '0;
    frame[START_IDX]  = 1'b0;
    frame[8:1]        = data;
    frame[PARITY_IDX] = ^data;
    frame[STOP_IDX]   = stopVal;
    for (int i = 0; i < FRAME_BITS_DEF; i++) begin
      RxIn = frame[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    RxIn = 1'b1;
  endtask

  task automatic gatherFrame(input int base, output logic [10:0] bits, output int badSpace);
    bits     = '0;
    badSpace = 0;
    for (int i = 0; i < FRAME_BITS_DEF; i++) begin
      bits[i] = bitLog[base + i];
      if (i > 0 && (strobeCyc[base + i] - strobeCyc[base + i - 1]) != BIT_CLKS) badSpace++;
    end
  endtask

  task automatic waitStrobes(input int target, input int budget);
    int n;
    n = 0;
    while (strobeCnt < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("reachStrobe", 32'(strobeCnt >= target), 1);
  endtask

  initial begin
    int          base;
    int          doneBase;
    int          bad;
    logic [10:0] bits;

    ResetN = 1'b0;
    Enable = 1'b0;
    RxIn   = 1'b1;
    repeat (5) @(negedge Clk);
    checkOutput("rstShiftEn", ShiftEn, 0);
    checkOutput("rstShiftBit", ShiftBit, 1);
    checkOutput("rstFrameDone", FrameDone, 0);
    checkOutput("rstFramingErr", FramingErr, 0);
    checkOutput("rstBusy", Busy, 0);
    ResetN = 1'b1;
    Enable = 1'b1;
    repeat (10) @(negedge Clk);

    base = strobeCnt; doneBase = doneCnt;
    applyStimulus(8'h55, 1'b1);
    repeat (20) @(negedge Clk);
    gatherFrame(base, bits, bad);
    checkOutput("f55Strobes", strobeCnt - base, 11);
    checkOutput("f55Bits", bits, 11'b10010101010);
    checkOutput("f55Spacing", bad, 0);
    checkOutput("f55Done", doneCnt - doneBase, 1);
    checkOutput("f55Err", errAtDone, 0);
    checkOutput("f55Busy", Busy, 0);

    // Stop bit forced low: the error must persist until a clean frame.
    base = strobeCnt; doneBase = doneCnt;
    applyStimulus(8'hA3, 1'b0);
    repeat (20) @(negedge Clk);
    checkOutput("fA3Strobes", strobeCnt - base, 11);
    checkOutput("fA3Done", doneCnt - doneBase, 1);
    checkOutput("fA3ErrAtDone", errAtDone, 1);
    repeat (200) @(negedge Clk);
    checkOutput("fA3ErrHold", FramingErr, 1);
    doneBase = doneCnt;
    applyStimulus(8'h81, 1'b1);
    repeat (20) @(negedge Clk);
    checkOutput("f81Done", doneCnt - doneBase, 1);
    checkOutput("f81ErrClr", FramingErr, 0);

    base = strobeCnt; doneBase = doneCnt;
    RxIn = 1'b0;
    repeat (3 * CLK_PER_TICK) @(negedge Clk);
    RxIn = 1'b1;
`ifdef UART_RX_START_VERIFY_EN
    repeat (3 * CLK_PER_TICK) @(negedge Clk);
    checkOutput("glitchBusyHigh", Busy, 1);
    repeat (40) @(negedge Clk);
    checkOutput("glitchBusyLow", Busy, 0);
    checkOutput("glitchStrobes", strobeCnt - base, 0);
    checkOutput("glitchDone", doneCnt - doneBase, 0);
`else
    repeat (BIT_CLKS * FRAME_BITS_DEF + 40) @(negedge Clk);
    gatherFrame(base, bits, bad);
    checkOutput("glitchStrobes", strobeCnt - base, 11);
    checkOutput("glitchFirstBit", bitLog[base], 1);
    checkOutput("glitchBits", bits, 11'h7FF);
    checkOutput("glitchDone", doneCnt - doneBase, 1);
`endif

    base = strobeCnt; doneBase = doneCnt;
    fork
      applyStimulus(8'h3C, 1'b1);
      begin
        waitStrobes(base + 5, 8 * BIT_CLKS);
        checkOutput("enDropBusyBefore", Busy, 1);
        Enable = 1'b0;
        @(negedge Clk);
        checkOutput("enDropBusy", Busy, 0);
      end
    join
    repeat (20) @(negedge Clk);
    checkOutput("enDropStrobes", strobeCnt - base, 5);
    checkOutput("enDropDone", doneCnt - doneBase, 0);
    Enable = 1'b1;
    repeat (10) @(negedge Clk);
    base = strobeCnt; doneBase = doneCnt;
    applyStimulus(8'h3C, 1'b1);
    repeat (20) @(negedge Clk);
    gatherFrame(base, bits, bad);
    checkOutput("f3CStrobes", strobeCnt - base, 11);
    checkOutput("f3CBits", bits, 11'b10001111000);
    checkOutput("f3CDone", doneCnt - doneBase, 1);
    checkOutput("f3CErr", errAtDone, 0);

    // Reset lands while the 7th strobe is still high and stays asserted to frame end.
    base = strobeCnt;
    fork
      applyStimulus(8'h55, 1'b1);
      begin
        waitStrobes(base + 7, 9 * BIT_CLKS);
        checkOutput("preRstShiftBit", ShiftBit, 0);
        ResetN = 1'b0;
        #1;
        checkOutput("midRstShiftEn", ShiftEn, 0);
        checkOutput("midRstShiftBit", ShiftBit, 1);
        checkOutput("midRstFrameDone", FrameDone, 0);
        checkOutput("midRstFramingErr", FramingErr, 0);
        checkOutput("midRstBusy", Busy, 0);
      end
    join
    repeat (5) @(negedge Clk);
    ResetN = 1'b1;
    repeat (10) @(negedge Clk);
    base = strobeCnt; doneBase = doneCnt;
    applyStimulus(8'hFF, 1'b1);
    repeat (20) @(negedge Clk);
    gatherFrame(base, bits, bad);
    checkOutput("fFFStrobes", strobeCnt - base, 11);
    checkOutput("fFFBits", bits, 11'h5FE);
    checkOutput("fFFDone", doneCnt - doneBase, 1);

    base = strobeCnt; doneBase = doneCnt;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    repeat (20) @(negedge Clk);
    checkOutput("b2bStrobes", strobeCnt - base, 22);
    checkOutput("b2bDone", doneCnt - doneBase, 2);
    gatherFrame(base, bits, bad);
    checkOutput("b2bBits0", bits, 11'h400);
    checkOutput("b2bSpacing0", bad, 0);
    gatherFrame(base + 11, bits, bad);
    checkOutput("b2bBits1", bits, 11'h5FE);
    checkOutput("b2bSpacing1", bad, 0);
    checkOutput("b2bErr", errAtDone, 0);

    checkOutput("noOverlap", overlapCnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART Rx path. It sits between the raw serial line and the serial-in/parallel-out frame register. It detects the start bit, times each bit cell from a 16x oversampling tick and issues one mid-bit shift strobe per frame bit. It signals frame completion and stop-bit framing errors to the downstream deframe unit.

## Interface

Parameters:
- OVERSAMPLE, 16, Tick16 pulses per bit cell; must be even and at least 4.
- FRAME_BITS, 11, bits per frame: start, 8 data, parity, stop.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- ResetN  input  1  reset, asynchronous, active-low.
- Tick16  input  1  single-cycle oversampling enable, OVERSAMPLE per bit period.
- Enable  input  1  receiver enable; low holds or forces IDLE.
- RxIn  input  1  asynchronous serial line; idles high.
- ShiftEn  output  1  one-cycle strobe; the shift register clocks ShiftBit on it.
- ShiftBit  output  1  sampled line value valid while ShiftEn is high.
- FrameDone  output  1  one-cycle pulse after the last bit is strobed.
- FramingErr  output  1  valid with FrameDone; high when the sampled stop bit is 0.
- Busy  output  1  high in START and SHIFT.

## Operation

- RxIn passes through a 2-flop synchronizer (RxS). Falling edge = previous RxS high and current RxS low.
- Counters:
  - TickCnt is $clog2(OVERSAMPLE) bits wide and wraps to 0 at OVERSAMPLE-1.
  - BitCnt is $clog2(FRAME_BITS+1) bits wide.
  - Both counters advance only on cycles where Tick16 is high.
- FSM states: IDLE, START, SHIFT, DONE.
  - IDLE: entered from reset. With Enable high and a falling edge detected, go to START with TickCnt=0 and BitCnt=0.
  - START: count Tick16. On the Tick16 with TickCnt==OVERSAMPLE/2-1 (mid start bit), sample RxS. Issue the strobe, set BitCnt=1 and TickCnt=0, then go to SHIFT.
  - SHIFT: on each Tick16 with TickCnt==OVERSAMPLE-1 (next mid-bit), sample RxS, strobe, and increment BitCnt. When BitCnt reaches FRAME_BITS, latch stop-bit error = !RxS and go to DONE.
  - DONE: one cycle. Pulse FrameDone and present FramingErr, then return to IDLE. A falling edge seen in this cycle is not lost: it is acted on in IDLE on the next cycle.
- Exactly FRAME_BITS strobes per completed frame. The first strobe carries the start bit (0 on a valid frame).
- Enable low in START or SHIFT: abort to IDLE on the next cycle. No further strobes, no FrameDone, counters cleared.
- Tick16 held high continuously is legal; the counters then advance every cycle.

## Timing

- Reset values: ShiftEn=0, ShiftBit=1, FrameDone=0, FramingErr=0, Busy=0, state IDLE, counters 0, synchronizer flops 1.
- Synchronizer latency: RxIn reaches RxS in 2 Clk cycles. Edge detection uses RxS.
- ShiftEn, ShiftBit, FrameDone and FramingErr are registered. ShiftEn/ShiftBit are high in the cycle after the qualifying Tick16.
- Strobe spacing: OVERSAMPLE Tick16 periods. The first strobe follows OVERSAMPLE/2 Tick16 after START entry.
- FrameDone is high in the cycle after the last ShiftEn, so ShiftEn and FrameDone are never high together.
- FramingErr holds its value until the next FrameDone or reset.
- Busy is combinational from state.
- ResetN assertion mid-frame clears everything asynchronously. Behaviour after release is as from power-up.

## Configuration

- UART_RX_START_VERIFY_EN:
  - Defined: at mid start bit, if RxS==1 the start is false. No strobe is issued, the FSM returns to IDLE, and BitCnt stays 0.
  - Undefined: the start bit is always accepted and strobed whatever its sampled value.

## Structure

- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, SHIFT, DONE);
  - default constants OVERSAMPLE_DEF=16 and FRAME_BITS_DEF=11;
  - the frame bit index constants (START_IDX, PARITY_IDX, STOP_IDX).
- Sub-module uart_rx_sync contains the 2-flop synchronizer and falling-edge detector. It outputs RxS and FallEdge and resets to RxS=1.

## Test plan

- Frame 0x55 with even parity 0 and stop 1, Tick16 every 4 Clk: exactly 11 ShiftEn pulses 64 Clk apart. ShiftBit sequence 0,1,0,1,0,1,0,1,0,0,1. One FrameDone with FramingErr=0. Busy low afterwards.
- Stop bit driven 0 on frame 0xA3: FrameDone with FramingErr=1. FramingErr stays 1 until the next good frame, which clears it.
- RxIn low glitch for 3 Tick16 only:
  - with UART_RX_START_VERIFY_EN: no ShiftEn, Busy high for 8 Tick16 then low;
  - without it: 11 strobes, first ShiftBit=1.
- Enable dropped after the 5th strobe: no further ShiftEn, no FrameDone, Busy=0 one cycle later. A following 0x3C frame is received correctly.
- ResetN pulsed low after the 7th strobe: all outputs 0 (ShiftBit=1) immediately. After release, the next frame 0xFF completes with 11 strobes.
- Back-to-back frames 0x00 then 0xFF with no idle gap beyond the stop bit: two FrameDone pulses and 22 strobes, with no strobe lost or duplicated.
